// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// Superscalar RV32I decode stage: DECODE_WIDTH lanes decoded per cycle into a
// registered output with a one-group skid buffer, flush and a lane counter.

package decode_stage_pkg;
    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] instruction_addr;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } instruction_t;
endpackage

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DECODE_WIDTH = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush_i,
    input  logic                                   in_valid_i,
    output logic                                   in_ready_o,
    input  logic [DECODE_WIDTH-1:0]                in_lane_mask_i,
    input  logic [DECODE_WIDTH-1:0][ADDR_WIDTH-1:0] in_addr_i,
    input  logic [DECODE_WIDTH-1:0][DATA_WIDTH-1:0] in_instr_i,
    output logic                                   out_valid_o,
    input  logic                                   out_ready_i,
    output logic [DECODE_WIDTH-1:0]                out_lane_mask_o,
    output instruction_t [DECODE_WIDTH-1:0]        out_decoded_o,
    output logic [DECODE_WIDTH-1:0]                out_illegal_o,
    output logic [CNT_WIDTH-1:0]                   decoded_count_o
);

    typedef struct packed {
        logic [DECODE_WIDTH-1:0]         mask;
        logic [DECODE_WIDTH-1:0]         illegal;
        instruction_t [DECODE_WIDTH-1:0] dec;
    } group_t;

    group_t                 out_grp_q, out_grp_d;
    group_t                 skid_grp_q, skid_grp_d;
    group_t                 in_grp;
    logic                   out_valid_q, out_valid_d;
    logic                   skid_valid_q, skid_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   accept;
    logic                   out_fire;
    logic                   out_load;

    function automatic void lane_decode(
        input  logic [XLEN-1:0] addr,
        input  logic [31:0]     instr,
        output instruction_t    d,
        output logic            bad
    );
        logic [2:0] f3;
        logic [6:0] f7;
        f3  = instr[14:12];
        f7  = instr[31:25];
        d   = '0;
        bad = 1'b0;
        case (instr[6:0])
            OPC_OP: begin
                bad      = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'b000 || f3 == 3'b101)));
                d.rd     = instr[11:7];
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.funct7 = f7;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                if (instr[6:0] == OPC_LOAD) begin
                    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                end else if (instr[6:0] == OPC_JALR) begin
                    bad = (f3 != 3'b000);
                end else begin
                    bad = ((f3 == 3'b001) && (f7 != 7'h00)) ||
                          ((f3 == 3'b101) && (f7 != 7'h00) && (f7 != 7'h20));
                end
                d.rd     = instr[11:7];
                d.rs1    = instr[19:15];
                d.funct3 = f3;
                d.imm    = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                bad      = (f3 >= 3'b011);
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                bad      = (f3 == 3'b010) || (f3 == 3'b011);
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.funct3 = f3;
                d.imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                d.rd  = instr[11:7];
                d.imm = {instr[31:12], 12'h000};
            end
            OPC_JAL: begin
                d.rd  = instr[11:7];
                d.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_SYSTEM: begin
                d.rd     = instr[11:7];
                d.rs1    = instr[19:15];
                d.funct3 = f3;
                d.imm    = {20'h00000, instr[31:20]};
            end
            // covers any opcode not listed, including instr[1:0] != 2'b11
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d = '0;
        end
        d.instruction_addr = addr;
        d.opcode           = instr[6:0];
    endfunction

    function automatic logic [CNT_WIDTH-1:0] lane_popcount(input logic [DECODE_WIDTH-1:0] m);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            n = n + CNT_WIDTH'(m[i]);
        end
        return n;
    endfunction

    always_comb begin
        instruction_t d;
        logic         bad;
        in_grp      = '0;
        in_grp.mask = in_lane_mask_i;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            d   = '0;
            bad = 1'b0;
            if (in_lane_mask_i[i]) begin
                lane_decode(XLEN'(in_addr_i[i]), in_instr_i[i], d, bad);
            end
            in_grp.dec[i]     = d;
            in_grp.illegal[i] = bad;
        end
    end

    assign accept   = in_valid_i && in_ready_q;
    assign out_fire = out_valid_q && out_ready_i;
    assign out_load = !out_valid_q || out_ready_i;

    // The skid only holds data while the output is stalled, so it always
    // drains into the output before any newer group can.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_grp_d    = out_grp_q;
        skid_valid_d = skid_valid_q;
        skid_grp_d   = skid_grp_q;
        count_d      = count_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            out_grp_d    = '0;
            skid_valid_d = 1'b0;
            skid_grp_d   = '0;
        end else begin
            if (out_fire) begin
                count_d = count_q + lane_popcount(out_grp_q.mask);
            end
            if (out_load) begin
                if (skid_valid_q) begin
                    out_grp_d    = skid_grp_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                    skid_grp_d   = '0;
                end else if (accept) begin
                    out_grp_d   = in_grp;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_grp_d   = in_grp;
                skid_valid_d = 1'b1;
            end
        end
    end

    assign in_ready_d = !skid_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_grp_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_grp_q   <= '0;
            in_ready_q   <= 1'b1;
            count_q      <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_grp_q    <= out_grp_d;
            skid_valid_q <= skid_valid_d;
            skid_grp_q   <= skid_grp_d;
            in_ready_q   <= in_ready_d;
            count_q      <= count_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_lane_mask_o = out_grp_q.mask;
    assign out_decoded_o   = out_grp_q.dec;
    assign out_illegal_o   = out_grp_q.illegal;
    assign decoded_count_o = count_q;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
// Scoreboard bench for decode_stage: accepted groups are modelled from the
// RV32I field rules and checked in order as rename takes them.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DW = 2;

    typedef struct packed {
        logic [DW-1:0]         mask;
        logic [DW-1:0]         ill;
        instruction_t [DW-1:0] dec;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready_o;
    logic [DW-1:0]         in_mask;
    logic [DW-1:0][31:0]   in_addr;
    logic [DW-1:0][31:0]   in_instr;
    logic                  out_valid_o;
    logic                  out_ready = 1'b0;
    logic [DW-1:0]         out_lane_mask_o;
    instruction_t [DW-1:0] out_decoded_o;
    logic [DW-1:0]         out_illegal_o;
    logic [31:0]           decoded_count_o;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_cnt = 0;
    bit          mon_en = 1'b0;

    decode_stage #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DECODE_WIDTH(DW), .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .in_lane_mask_i(in_mask), .in_addr_i(in_addr), .in_instr_i(in_instr),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_lane_mask_o(out_lane_mask_o), .out_decoded_o(out_decoded_o),
        .out_illegal_o(out_illegal_o), .decoded_count_o(decoded_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: fields computed with integer shifts/masks from the ISA rules.
    function automatic void model_lane(input bit present, input logic [31:0] a,
                                       input logic [31:0] ins,
                                       output instruction_t d, output bit ill);
        int unsigned op, f3, f7, u;
        int          s;
        d = '0;
        ill = 1'b0;
        if (!present) return;
        u  = ins;
        s  = int'(ins);
        op = u & 127;
        f3 = (u >> 12) & 7;
        f7 = u >> 25;
        case (op)
            3:   ill = (f3 == 3) || (f3 >= 6);
            35:  ill = (f3 >= 3);
            99:  ill = (f3 == 2) || (f3 == 3);
            103: ill = (f3 != 0);
            51:  ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
            19:  ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
            55, 23, 111, 115: ill = 1'b0;
            default: ill = 1'b1;
        endcase
        d.instruction_addr = a;
        d.opcode = 7'(op);
        if (ill) return;
        case (op)
            51: begin
                d.rd = 5'(u >> 7); d.rs1 = 5'(u >> 15); d.rs2 = 5'(u >> 20);
                d.funct3 = 3'(f3); d.funct7 = 7'(f7);
            end
            3, 19, 103: begin
                d.rd = 5'(u >> 7); d.rs1 = 5'(u >> 15); d.funct3 = 3'(f3);
                d.imm = s >>> 20;
            end
            35: begin
                d.rs1 = 5'(u >> 15); d.rs2 = 5'(u >> 20); d.funct3 = 3'(f3);
                d.imm = ((s >>> 25) <<< 5) | int'((u >> 7) & 31);
            end
            99: begin
                d.rs1 = 5'(u >> 15); d.rs2 = 5'(u >> 20); d.funct3 = 3'(f3);
                d.imm = ((s >>> 31) <<< 12) | int'(((u >> 7) & 1) << 11) |
                        int'(((u >> 25) & 63) << 5) | int'(((u >> 8) & 15) << 1);
            end
            55, 23: begin
                d.rd = 5'(u >> 7); d.imm = u & 32'hFFFFF000;
            end
            111: begin
                d.rd = 5'(u >> 7);
                d.imm = ((s >>> 31) <<< 20) | int'(((u >> 12) & 255) << 12) |
                        int'(((u >> 20) & 1) << 11) | int'(((u >> 21) & 1023) << 1);
            end
            default: begin
                d.rd = 5'(u >> 7); d.rs1 = 5'(u >> 15); d.funct3 = 3'(f3);
                d.imm = u >> 20;
            end
        endcase
    endfunction

    function automatic exp_t build_exp(input logic [DW-1:0] m, input logic [DW-1:0][31:0] a,
                                       input logic [DW-1:0][31:0] ins);
        exp_t         e;
        instruction_t d;
        bit           il;
        e = '0;
        e.mask = m;
        for (int i = 0; i < DW; i++) begin
            model_lane(m[i], a[i], ins[i], d, il);
            e.dec[i] = d;
            e.ill[i] = il;
        end
        return e;
    endfunction

    function automatic int lanes_in(input logic [DW-1:0] m);
        int n = 0;
        for (int i = 0; i < DW; i++) n += int'(m[i]);
        return n;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) return w;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'h03;  1: w[6:0] = 7'h23;  2: w[6:0] = 7'h13;
            3: w[6:0] = 7'h33;  4: w[6:0] = 7'h37;  5: w[6:0] = 7'h17;
            6: w[6:0] = 7'h6F;  7: w[6:0] = 7'h67;  8: w[6:0] = 7'h63;
            default: w[6:0] = 7'h73;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // Acceptance side of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #4;
            if (rst_n && in_valid && in_ready_o && !flush) begin
                e = build_exp(in_mask, in_addr, in_instr);
                @(posedge clk);
                if (rst_n) exp_q.push_back(e);
            end
        end
    end

    // Output monitor.
    initial begin
        exp_t cur, prev, e;
        bit   stalled_prev;
        stalled_prev = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk); #4;
            if (mon_en && rst_n) begin
                cur = {out_lane_mask_o, out_illegal_o, out_decoded_o};
                check("out_valid", 256'(out_valid_o), 256'(exp_q.size() != 0));
                check("in_ready", 256'(in_ready_o), 256'(exp_q.size() < 2));
                check("count", 256'(decoded_count_o), 256'(model_cnt));
                if (stalled_prev && out_valid_o) check("stall_stable", 256'(cur), 256'(prev));
                if (flush) begin
                    exp_q.delete();
                    stalled_prev = 1'b0;
                end else begin
                    if (out_valid_o && out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_output actual=%0h expected=none", cur);
                        end else begin
                            e = exp_q.pop_front();
                            check("group", 256'(cur), 256'(e));
                            model_cnt = model_cnt + 32'(lanes_in(e.mask));
                        end
                    end
                    stalled_prev = out_valid_o && !out_ready;
                    prev = cur;
                end
            end else begin
                stalled_prev = 1'b0;
            end
        end
    end

    task automatic drive_group(input logic [DW-1:0] m, input logic [31:0] a0, input logic [31:0] i0,
                               input logic [31:0] a1, input logic [31:0] i1);
        in_mask = m;
        in_addr[0] = a0;  in_instr[0] = i0;
        in_addr[1] = a1;  in_instr[1] = i1;
        in_valid = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DW-1:0] m, input logic [31:0] a0, input logic [31:0] i0,
                        input logic [31:0] a1, input logic [31:0] i1);
        int n;
        drive_group(m, a0, i0, a1, i1);
        n = 0;
        #4;
        while (!in_ready_o && n < 50) begin
            @(negedge clk); #4;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=in_ready_low expected=accept");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        logic [31:0] cnt_before;
        in_mask = '0;
        in_addr = '0;
        in_instr = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 256'(out_valid_o), 256'(0));
        check("rst_in_ready", 256'(in_ready_o), 256'(1));
        check("rst_mask", 256'(out_lane_mask_o), 256'(0));
        check("rst_decoded", 256'(out_decoded_o), 256'(0));
        check("rst_illegal", 256'(out_illegal_o), 256'(0));
        check("rst_count", 256'(decoded_count_o), 256'(0));
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        out_ready = 1'b1;
        send(2'b11, 32'h100, 32'h00500093, 32'h104, 32'h0080A103);
        #4;
        check("t1_valid", 256'(out_valid_o), 256'(1));
        check("t1_l0_rd", 256'(out_decoded_o[0].rd), 256'(1));
        check("t1_l0_rs1", 256'(out_decoded_o[0].rs1), 256'(0));
        check("t1_l0_imm", 256'(out_decoded_o[0].imm), 256'(5));
        check("t1_l1_rd", 256'(out_decoded_o[1].rd), 256'(2));
        check("t1_l1_rs1", 256'(out_decoded_o[1].rs1), 256'(1));
        check("t1_l1_f3", 256'(out_decoded_o[1].funct3), 256'(2));
        check("t1_l1_imm", 256'(out_decoded_o[1].imm), 256'(8));
        @(negedge clk); #4;
        check("t1_count", 256'(decoded_count_o), 256'(2));
        @(negedge clk);

        send(2'b11, 32'h200, 32'h0020A623, 32'h204, 32'hFE208EE3);
        #4;
        check("s_imm", 256'(out_decoded_o[0].imm), 256'(12));
        check("s_rs1", 256'(out_decoded_o[0].rs1), 256'(1));
        check("s_rs2", 256'(out_decoded_o[0].rs2), 256'(2));
        check("b_imm", 256'(out_decoded_o[1].imm), 256'(32'hFFFFFFFC));
        @(negedge clk);
        send(2'b11, 32'h208, 32'h123452B7, 32'h20C, 32'h008000EF);
        #4;
        check("u_imm", 256'(out_decoded_o[0].imm), 256'(32'h12345000));
        check("u_rd", 256'(out_decoded_o[0].rd), 256'(5));
        check("j_imm", 256'(out_decoded_o[1].imm), 256'(8));
        check("j_rd", 256'(out_decoded_o[1].rd), 256'(1));
        @(negedge clk);

        send(2'b11, 32'h300, 32'hFFFFFFFF, 32'h304, 32'h02208033);
        #4;
        check("ill_bits", 256'(out_illegal_o), 256'(2'b11));
        check("ill_l1_rs1", 256'(out_decoded_o[1].rs1), 256'(0));
        check("ill_l1_rs2", 256'(out_decoded_o[1].rs2), 256'(0));
        check("ill_l1_op", 256'(out_decoded_o[1].opcode), 256'(7'h33));
        @(negedge clk);
        send(2'b01, 32'h310, 32'h00500093, 32'h314, 32'h0080A103);
        #4;
        check("empty_lane_ill", 256'(out_illegal_o), 256'(0));
        check("empty_lane_dec", 256'(out_decoded_o[1]), 256'(0));
        @(negedge clk);

        // Backpressure: A in output, B in skid, C waits at fetch.
        out_ready = 1'b0;
        send(2'b11, 32'h400, 32'h00100093, 32'h404, 32'h00200113);
        send(2'b11, 32'h408, 32'h00300193, 32'h40C, 32'h00400213);
        fork
            send(2'b10, 32'h410, 32'h00500293, 32'h414, 32'h00600313);
            begin
                #4;
                check("bp_in_ready", 256'(in_ready_o), 256'(0));
                check("bp_out_valid", 256'(out_valid_o), 256'(1));
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);

        // Flush with a full skid and a group presented in the flush cycle.
        out_ready = 1'b0;
        send(2'b11, 32'h500, 32'h00700393, 32'h504, 32'h00800413);
        send(2'b11, 32'h508, 32'h00900493, 32'h50C, 32'h00A00513);
        cnt_before = model_cnt;
        drive_group(2'b11, 32'h510, 32'h00B00593, 32'h514, 32'h00C00613);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #4;
        check("flush_out_valid", 256'(out_valid_o), 256'(0));
        check("flush_in_ready", 256'(in_ready_o), 256'(1));
        check("flush_count", 256'(decoded_count_o), 256'(cnt_before));
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 9) < 6)
                drive_group(2'($urandom), $urandom & 32'hFFFFFFFC, rand_instr(),
                            $urandom & 32'hFFFFFFFC, rand_instr());
            else
                in_valid = 1'b0;
            @(negedge clk);
        end
        drain();

        // Asynchronous reset while a group is held on the output.
        out_ready = 1'b0;
        send(2'b11, 32'h600, 32'h00D00693, 32'h604, 32'h00E00713);
        mon_en = 1'b0;
        #1;
        check("pre_rst_valid", 256'(out_valid_o), 256'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 256'(out_valid_o), 256'(0));
        check("async_rst_count", 256'(decoded_count_o), 256'(0));
        check("async_rst_ready", 256'(in_ready_o), 256'(1));
        exp_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        send(2'b01, 32'h700, 32'h00F00793, 32'h704, 32'h0);
        drain();
        check("final_count", 256'(decoded_count_o), 256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Superscalar successor to the single-instruction combinational decoder. Decodes DECODE_WIDTH instructions per cycle from fetch and registers the results. Uses a valid/ready handshake with a one-group skid buffer, so downstream backpressure never combinationally reaches fetch. Adds per-lane illegal-instruction detection, pipeline flush, and a decoded-instruction counter. Sits between fetch and rename.

Parameters:
ADDR_WIDTH, 32, instruction address width
DATA_WIDTH, 32, instruction width (only 32 is supported)
DECODE_WIDTH, 2, lanes per group (1..4)
CNT_WIDTH, 32, width of the performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard all buffered and incoming groups
in_valid_i  in  1  fetch group valid
in_ready_o  out  1  decode can accept a group
in_lane_mask_i  in  DECODE_WIDTH  per-lane instruction present
in_addr_i  in  DECODE_WIDTH x ADDR_WIDTH  per-lane PC
in_instr_i  in  DECODE_WIDTH x DATA_WIDTH  per-lane instruction word
out_valid_o  out  1  decoded group valid
out_ready_i  in  1  rename accepts the group
out_lane_mask_o  out  DECODE_WIDTH  lanes present
out_decoded_o  out  DECODE_WIDTH x instruction_t  decoded fields per lane
out_illegal_o  out  DECODE_WIDTH  lane holds an illegal encoding
decoded_count_o  out  CNT_WIDTH  total lanes handed to rename

Behaviour:
- Reset (async, rst_n=0): out_valid_o=0, in_ready_o=1, skid empty, out_lane_mask_o=0, out_decoded_o=0, out_illegal_o=0, decoded_count_o=0.
- Accept: a group is accepted when in_valid_i && in_ready_o. in_ready_o is driven only by a flop (= !skid_full).
- Latency: an accepted group appears on the out_* ports on the next cycle if the output register is empty or draining. Otherwise it goes into the skid.
- Output register: loads when empty, or when out_ready_i=1 and out_valid_o=1. Source priority: skid first, then incoming.
- Skid: fills when a group is accepted while the output holds and is stalled (out_valid_o && !out_ready_i). in_ready_o falls the cycle after the skid fills and rises the cycle after the skid drains.
- Ordering: groups leave strictly in acceptance order.
- Payload stability: out_* payload stays unchanged while out_valid_o=1 and out_ready_i=0.
- Flush: on the next edge, output register and skid are cleared, out_valid_o=0, in_ready_o=1. A group presented in the flush cycle is dropped. Flush has priority over accept and handshake.
- Empty lanes: lanes with mask bit 0 output all-zero fields and illegal=0.
- Per-lane field decode by opcode (instruction_t):
  - I-type (LOAD, OP_IMM, JALR): imm = sign-extended [31:20].
  - S-type (STORE): imm = {[31:25],[11:7]}, sign-extended.
  - B-type (BRANCH): imm = {[31],[7],[30:25],[11:8],0}, sign-extended.
  - U-type (LUI, AUIPC): imm = {[31:12],12'h000}.
  - J-type (JAL): imm = {[31],[19:12],[20],[30:21],0}, sign-extended.
  - SYSTEM: imm = zero-extended [31:20].
  - Unused register/funct fields are 0, as in the current decoder.
- Illegal-encoding rules; an illegal lane outputs all other fields = 0 except instruction_addr and opcode:
  - instr[1:0]!=2'b11.
  - Opcode outside {LOAD, STORE, OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, SYSTEM}.
  - LOAD funct3 in {011,110,111}; STORE funct3 >= 011.
  - BRANCH funct3 in {010,011}; JALR funct3 != 000.
  - OP funct7 not in {0000000,0100000}, or funct7=0100000 with funct3 not in {000,101}.
  - OP_IMM shift with funct3=001 and funct7 != 0; funct3=101 with funct7 not in {0000000,0100000}.
- Counter: on each output handshake, decoded_count_o += popcount(out_lane_mask_o). Wraps modulo 2^CNT_WIDTH. Not cleared by flush.

Test Plan:
- Single group, DECODE_WIDTH=2: lane0 0x00500093 @0x100, lane1 0x0080A103 @0x104, out_ready_i=1.
  - Next cycle: out_valid_o=1; lane0 rd=1, rs1=0, imm=5; lane1 rd=2, rs1=1, funct3=010, imm=8; count becomes 2.
- Immediates:
  - 0x0020A623 -> imm=12, rs1=1, rs2=2.
  - 0xFE208EE3 -> imm=0xFFFFFFFC.
  - 0x123452B7 -> imm=0x12345000, rd=5.
  - 0x008000EF -> imm=8, rd=1.
- Illegal: 0xFFFFFFFF and 0x02208033 -> out_illegal_o=1 for those lanes, rd/rs fields 0; mask 2'b01 -> lane1 all zero, illegal=0.
- Backpressure: hold out_ready_i=0 and stream 3 groups.
  - Group A in output, B in skid, in_ready_o=0; C held by fetch.
  - Release out_ready_i: order A, B, C; no loss or duplication; payload stable while stalled.
- Flush with full skid: assert flush_i with in_valid_i=1.
  - Next cycle: out_valid_o=0, in_ready_o=1; the flush-cycle group is never output; count unchanged.
- Reset mid-stream: rst_n low asynchronously with out_valid_o=1 -> immediately out_valid_o=0, count=0, in_ready_o=1.
